// File: rtl/uio_arb_pkg.sv
// Shared types for the uio pin-bank arbiter.
package uio_arb_pkg;
  typedef enum logic [1:0] {IDLE, TURN, GRANT} uio_arb_state_t;
  localparam int UIO_W = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from ptr+1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   owner,
  output logic            any
);
  // Scan from farthest to nearest so the nearest candidate overwrites the rest.
  always_comb begin
    owner = '0;
    any   = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        owner = IW'((int'(ptr) + k) % NREQ);
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uio_arbiter.sv
// Round-robin owner of the uio pin bank with a turnaround gap between owners.
// Define UIO_ARB_TIMEOUT_EN to force release after MAX_BURST grant cycles.
module uio_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     dir,
  input  logic [8*NREQ-1:0]   wdata,
  input  logic [UIO_W-1:0]    uio_in,
  output logic [NREQ-1:0]     gnt,
  output logic [UIO_W-1:0]    uio_out,
  output logic [UIO_W-1:0]    uio_oe,
  output logic [UIO_W-1:0]    rdata,
  output logic [NREQ-1:0]     rvalid
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES - 1);

  uio_arb_state_t state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d, ptr_q, ptr_d, pick_ptr, pick_owner;
  logic           dir_q, dir_d, pick_any, timeout;
  logic [1:0]     turn_q, turn_d;
  logic [NREQ-1:0]  gnt_d, rvalid_d;
  logic [UIO_W-1:0] out_d, oe_d;

  // On a release edge ptr is about to become owner, so scan from owner directly.
  assign pick_ptr = (state_q == GRANT) ? owner_q : ptr_q;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .owner (pick_owner),
    .any   (pick_any)
  );

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] burst_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             burst_q <= '0;
    else if (ena && state_q == GRANT)    burst_q <= burst_q + 8'd1;
    else                                 burst_q <= '0;
  end
  assign timeout = (state_q == GRANT) && (burst_q == 8'(MAX_BURST - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      dir_q   <= 1'b0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    turn_d  = turn_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (pick_any) begin
          state_d = TURN;
          owner_d = pick_owner;
          dir_d   = dir[pick_owner];
          turn_d  = TURN_LOAD;
        end
        TURN: begin
          if (turn_q == 2'd0) state_d = GRANT;
          else                turn_d  = turn_q - 2'd1;
        end
        GRANT: if (!req[owner_q] || timeout) begin
          ptr_d = owner_q;
          if (pick_any) begin
            state_d = TURN;
            owner_d = pick_owner;
            dir_d   = dir[pick_owner];
            turn_d  = TURN_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pad-side values are computed from the next state so they register with it.
  always_comb begin
    gnt_d    = '0;
    oe_d     = '0;
    out_d    = '0;
    rvalid_d = '0;
    if (state_d == GRANT) begin
      gnt_d[owner_d] = 1'b1;
      oe_d           = {UIO_W{dir_d}};
      if (dir_d) out_d = wdata[8*int'(owner_d) +: 8];
    end
    if (ena) rvalid_d = gnt & {NREQ{~dir_q}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      uio_oe  <= '0;
      uio_out <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      gnt     <= gnt_d;
      uio_oe  <= oe_d;
      uio_out <= out_d;
      rvalid  <= rvalid_d;
      rdata   <= uio_in;
    end
  end
endmodule

// File: tb/tb_uio_arbiter.sv
// Directed bench for uio_arbiter (NREQ=4, TURN_CYCLES=1); timeout case needs UIO_ARB_TIMEOUT_EN.
module tb_uio_arbiter;
  logic        clk, rst, ena;
  logic [3:0]  req, dir, gnt, rvalid;
  logic [31:0] wdata;
  logic [7:0]  uio_in, uio_out, uio_oe, rdata;
  int n_tests = 0;
  int n_fail  = 0;

  uio_arbiter #(.NREQ(4), .TURN_CYCLES(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .uio_in(uio_in), .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe),
    .rdata(rdata), .rvalid(rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};
  logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1; ena = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_oe", uio_oe, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_out", uio_out, 0);
    chk("rst_rvalid", rvalid, 0);

    // single writer
    req = 4'b0001; dir = 4'b1111; wdata[7:0] = 8'hA5;
    tick();
    chk("w_turn_gnt", gnt, 0);
    chk("w_turn_oe", uio_oe, 0);
    tick();
    chk("w_gnt", gnt, 4'b0001);
    chk("w_oe", uio_oe, 8'hFF);
    chk("w_out", uio_out, 8'hA5);
    tick();
    chk("w_out2", uio_out, 8'hA5);
    wdata[7:0] = 8'h5A; dir = 4'b0000;
    tick();
    chk("w_out_lat", uio_out, 8'h5A);
    chk("w_dir_ignored", uio_oe, 8'hFF);
    req = 4'b0000;
    tick();
    chk("w_rel_gnt", gnt, 0);
    chk("w_rel_oe", uio_oe, 0);
    chk("w_rel_out", uio_out, 0);

    // round robin over all four
    do_reset();
    dir = 4'b1111;
    wdata = {bytes[3], bytes[2], bytes[1], bytes[0]};
    req = 4'b1111;
    tick();
    chk("rr_turn0", gnt, 0);
    foreach (seq[s]) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rr_gnt_s%0d_c%0d", s, c), gnt, 4'b0001 << seq[s]);
        chk($sformatf("rr_oe_s%0d_c%0d", s, c), uio_oe, 8'hFF);
        chk($sformatf("rr_out_s%0d_c%0d", s, c), uio_out, bytes[seq[s]]);
        if (c == 2) req[seq[s]] = 1'b0;
        tick();
      end
      chk($sformatf("rr_gap_gnt_s%0d", s), gnt, 0);
      chk($sformatf("rr_gap_oe_s%0d", s), uio_oe, 0);
      req[seq[s]] = 1'b1;
    end
    req = 4'b0000;
    tick();

    // reader on requester 2
    tick();
    req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
    tick();
    chk("r_turn_gnt", gnt, 0);
    tick();
    chk("r_gnt", gnt, 4'b0100);
    chk("r_oe", uio_oe, 0);
    chk("r_rvalid_lag", rvalid, 0);
    tick();
    chk("r_rvalid", rvalid, 4'b0100);
    chk("r_rdata", rdata, 8'h3C);
    chk("r_oe2", uio_oe, 0);
    uio_in = 8'hC3;
    tick();
    chk("r_rdata2", rdata, 8'hC3);
    req = 4'b0000;
    tick();
    chk("r_rel_gnt", gnt, 0);
    chk("r_rel_rvalid", rvalid, 4'b0100);
    tick();
    chk("r_rel_rvalid2", rvalid, 0);

    // async reset mid-grant
    req = 4'b0010; dir = 4'b1111;
    tick(); tick();
    chk("ar_gnt_pre", gnt, 4'b0010);
    chk("ar_out_pre", uio_out, 8'h22);
    rst = 1'b1;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_oe", uio_oe, 0);
    chk("ar_out", uio_out, 0);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    chk("ar_next_gnt", gnt, 4'b0001);

    // enable drop mid-grant
    ena = 1'b0;
    tick();
    chk("en_gnt", gnt, 0);
    chk("en_oe", uio_oe, 0);
    chk("en_out", uio_out, 0);
    chk("en_rvalid", rvalid, 0);
    tick();
    ena = 1'b1;
    tick();
    chk("en_turn", gnt, 0);
    tick();
    chk("en_regrant", gnt, 4'b0001);
    chk("en_regrant_oe", uio_oe, 8'hFF);

`ifdef UIO_ARB_TIMEOUT_EN
    req = 4'b0000;
    do_reset();
    req = 4'b0011;
    tick();
    chk("to_turn", gnt, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("to_gnt_r%0d_c%0d", r, c), gnt, (r % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      tick();
      chk($sformatf("to_gap_r%0d", r), gnt, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
